// File: rtl/alu_seq_if.sv
// Request/response channel between a client and the alu_seq front-end.
// rsp_err exists only when ALU_SEQ_ERR_EN is defined.
interface alu_seq_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [3:0]       req_op;
  logic [CNT_W-1:0] req_count;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;
`ifdef ALU_SEQ_ERR_EN
  logic             rsp_err;

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_count, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );
  modport master (
    output req_valid, req_a, req_b, req_op, req_count, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );
`else
  modport slave (
    input  req_valid, req_a, req_b, req_op, req_count, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags
  );
  modport master (
    output req_valid, req_a, req_b, req_op, req_count, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags
  );
`endif
endinterface

// File: rtl/alu_seq.sv
// Sequencer in front of a combinational 16-bit ALU; iterates SHL for multi-bit shifts.
// Optional macro ALU_SEQ_ERR_EN adds rsp_err and suppresses ALU use for opcodes > 7.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_seq_if.slave         bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [3:0]       alu_flags
);
  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_SHL  = 4'd7;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic [3:0]       rsp_flags_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [3:0]       alu_op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sticky_q;
  logic             no_carry_q;
  logic             carry_d;
  logic             unused_ovf;

  assign unused_ovf = alu_flags[3];

  // A zero-count SHL runs as a PASS of A, which must not report a carry.
  assign carry_d = no_carry_q ? 1'b0 : (sticky_q | alu_flags[1]);

`ifdef ALU_SEQ_ERR_EN
  logic err_q;
  logic rsp_err_q;
  assign bus.rsp_err = rsp_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= OP_PASS;
      cnt_q        <= '0;
      sticky_q     <= 1'b0;
      no_carry_q   <= 1'b0;
`ifdef ALU_SEQ_ERR_EN
      err_q        <= 1'b0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            alu_a_q     <= bus.req_a;
            alu_b_q     <= bus.req_b;
            alu_op_q    <= bus.req_op;
            cnt_q       <= (bus.req_op == OP_SHL) ? bus.req_count : CNT_W'(1);
            sticky_q    <= 1'b0;
            no_carry_q  <= 1'b0;
            req_ready_q <= 1'b0;
            state_q     <= EXEC;
            if (bus.req_op == OP_SHL && bus.req_count == '0) begin
              alu_op_q   <= OP_PASS;
              alu_b_q    <= bus.req_a;
              cnt_q      <= CNT_W'(1);
              no_carry_q <= 1'b1;
            end
`ifdef ALU_SEQ_ERR_EN
            err_q <= bus.req_op[3];
            if (bus.req_op[3]) begin
              alu_op_q <= OP_PASS;
              alu_b_q  <= '0;
            end
`endif
          end
        end
        EXEC: begin
          sticky_q <= sticky_q | alu_flags[1];
          cnt_q    <= cnt_q - CNT_W'(1);
          if (cnt_q > CNT_W'(1)) begin
            alu_a_q <= alu_out;
          end else begin
            rsp_result_q <= alu_out;
            rsp_flags_q  <= {1'b0, alu_flags[2], carry_d, alu_flags[0]};
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
`ifdef ALU_SEQ_ERR_EN
            rsp_err_q    <= err_q;
`endif
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
`ifdef ALU_SEQ_ERR_EN
            rsp_err_q   <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_op         = alu_op_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural model of the 16-bit ALU.
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_op, alu_flags;
  int          n_chk = 0;
  int          n_bad = 0;
  logic [15:0] trace_a[$];

  alu_seq_if #(.WIDTH(16), .CNT_W(4)) bus ();

  alu_seq #(.WIDTH(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_flags(alu_flags)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] alu_model(input logic [15:0] a, b, input logic [3:0] op);
    logic [16:0] w;
    w = '0;
    case (op)
      4'd0: w = {1'b0, b};
      4'd1: w = {1'b0, a | b};
      4'd2: w = {1'b0, a & b};
      4'd3: w = {1'b0, a ^ b};
      4'd4: w = {1'b0, ~a};
      4'd5: w = {1'b0, a} + {1'b0, b};
      4'd6: w = {(a < b), a - b};
      4'd7: w = {a, 1'b0};
      default: w = '0;
    endcase
    return {1'b0, w[15], w[16], (w[15:0] == 16'd0), w[15:0]};
  endfunction

  always_comb {alu_flags, alu_out} = alu_model(alu_a, alu_b, alu_op);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [15:0] a, b, input logic [3:0] cnt);
    int w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    check("req_ready before send", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_count = cnt;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int exp_lat,
                          input logic [15:0] exp_res, input logic [3:0] exp_flg);
    int lat = 0;
    trace_a.delete();
    @(negedge clk);
    while (!bus.rsp_valid && lat < 40) begin
      trace_a.push_back(alu_a);
      lat++;
      @(negedge clk);
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, 32'(bus.rsp_result), 32'(exp_res));
    check({tag, " flags"}, 32'(bus.rsp_flags), 32'(exp_flg));
  endtask

  task automatic ack(input string tag);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    check({tag, " valid after ack"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, " ready after ack"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    bus.req_count = '0;
    bus.rsp_ready = 1'b0;
    #12;
    check("reset req_ready", 32'(bus.req_ready), 32'd1);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset alu_op", 32'(alu_op), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    send(4'd5, 16'd250, 16'd7, 4'd0);
    wait_rsp("add", 1, 16'd257, 4'b0000); ack("add");

    send(4'd6, 16'd5, 16'd5, 4'd0);
    wait_rsp("sub", 1, 16'd0, 4'b0001); ack("sub");

    send(4'd7, 16'h4001, 16'd0, 4'd3);
    wait_rsp("shl3", 3, 16'h0008, 4'b0010);
    check("shl3 trace len", 32'(trace_a.size()), 32'd3);
    if (trace_a.size() == 3) begin
      check("shl3 alu_a pass1", 32'(trace_a[0]), 32'h4001);
      check("shl3 alu_a pass2", 32'(trace_a[1]), 32'h8002);
      check("shl3 alu_a pass3", 32'(trace_a[2]), 32'h0004);
    end
    ack("shl3");

    send(4'd7, 16'h9234, 16'd0, 4'd0);
    wait_rsp("shl0", 1, 16'h9234, 4'b0100); ack("shl0");

    send(4'd7, 16'h8000, 16'd0, 4'd1);
    wait_rsp("shl1", 1, 16'h0000, 4'b0011); ack("shl1");

    send(4'd5, 16'hFFFF, 16'd2, 4'd0);
    wait_rsp("add carry", 1, 16'h0001, 4'b0010); ack("add carry");

    send(4'd4, 16'h0000, 16'h1234, 4'd0);
    wait_rsp("not", 1, 16'hFFFF, 4'b0100); ack("not");

    send(4'd1, 16'd8, 16'd2, 4'd0);
    wait_rsp("or", 1, 16'd10, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp result", 32'(bus.rsp_result), 32'd10);
      check("bp valid", 32'(bus.rsp_valid), 32'd1);
      check("bp req_ready", 32'(bus.req_ready), 32'd0);
    end
    ack("or");

    send(4'd12, 16'd3, 16'd4, 4'd0);
    wait_rsp("illegal", 1, 16'd0, 4'b0001);
`ifdef ALU_SEQ_ERR_EN
    check("illegal err", 32'(bus.rsp_err), 32'd1);
    check("illegal alu_op", 32'(alu_op), 32'd0);
`else
    check("illegal alu_op", 32'(alu_op), 32'd12);
`endif
    ack("illegal");

    send(4'd7, 16'd1, 16'd0, 4'd15);
    repeat (4) @(posedge clk);
    #1 check("midop alu_a", 32'(alu_a), 32'h0010);
    #1 rst_n = 1'b0;
    #1;
    check("midrst req_ready", 32'(bus.req_ready), 32'd1);
    check("midrst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst result", 32'(bus.rsp_result), 32'd0);
    check("midrst flags", 32'(bus.rsp_flags), 32'd0);
    check("midrst alu_a", 32'(alu_a), 32'd0);
    check("midrst alu_b", 32'(alu_b), 32'd0);
    check("midrst alu_op", 32'(alu_op), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post rst no rsp", 32'(bus.rsp_valid), 32'd0);

    send(4'd5, 16'd1, 16'd1, 4'd0);
    wait_rsp("add after rst", 1, 16'd2, 4'b0000); ack("add after rst");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Request/response front-end that drives the combinational 16-bit ALU; it is the initiator of the ALU's operand/op/flags interface.
- Accepts one operation per valid/ready handshake and drives the ALU's A, B and op inputs from registered operands.
- Samples the ALU result and flags, and returns them on a valid/ready response channel.
- Adds multi-bit left shift by iterating the ALU's single-bit SHL pass.

Parameters:
- WIDTH, 16, data width of operands and result.
- CNT_W, 4, width of shift-count field (max shift 2^CNT_W-1 = 15).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- req_op  in  4  opcode: PASS=0, OR=1, AND=2, XOR=3, NOT=4, ADD=5, SUB=6, SHL=7
- req_count  in  CNT_W  shift amount, used only for SHL
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  WIDTH  final result
- rsp_flags  out  4  bit0 zero, bit1 carry, bit2 sign, bit3 overflow (always 0)
- alu_a  out  WIDTH  to ALU A
- alu_b  out  WIDTH  to ALU B
- alu_op  out  4  to ALU op
- alu_out  in  WIDTH  from ALU result
- alu_flags  in  4  from ALU flags

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; req_ready=1; rsp_valid=0.
  - rsp_result=0, rsp_flags=0; alu_a=0, alu_b=0, alu_op=0 (PASS).
  - All internal counters are cleared.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch alu_a=req_a, alu_b=req_b, alu_op=req_op.
  - Load remaining-pass counter: SHL uses req_count; every other op uses 1.
  - Clear sticky carry; go to EXEC.
- SHL with req_count=0:
  - Latch alu_op=PASS and alu_b=req_a, counter=1.
  - Result is A, flags from the ALU, carry forced 0.
- EXEC:
  - req_ready=0. The ALU is combinational; each EXEC cycle is one pass.
  - Each edge: sticky_carry |= alu_flags[1]; counter decrements.
  - If counter>1: alu_a<=alu_out (feedback); stay in EXEC.
  - If counter==1:
    - rsp_result<=alu_out.
    - rsp_flags<={1'b0, alu_flags[2], sticky_carry|alu_flags[1], alu_flags[0]}.
    - Go to RESP.
- Flags on multi-pass SHL: zero and sign come from the final pass; carry is the OR of all passes.
- RESP:
  - rsp_valid=1; rsp_result and rsp_flags are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: go to IDLE.
  - req_ready returns to 1 the following cycle; there is no same-cycle bypass.
- Latency: handshake on edge 0; rsp_valid goes high after edge N, where N = passes (1 for non-SHL, max(count,1) for SHL).
- Opcodes 8-15: forwarded unchanged, single pass; the ALU returns 0, so rsp_result=0 and zero flag=1.
- Requests while not IDLE: ignored (req_ready=0). A held req_valid is taken on the first IDLE cycle.
- Reset mid-operation: immediate return to reset values; the partial result is discarded and no response is issued.
- Width: all arithmetic is done by the ALU. The counter does not wrap, since it stops at 1.

Optional Feature:
- Macro ALU_SEQ_ERR_EN.
- Defined:
  - Adds output port rsp_err (1 bit), reset 0.
  - Set in RESP when the latched opcode is >7, otherwise 0; held with rsp_valid.
  - For illegal opcodes the ALU is not exercised: alu_op is driven as PASS with alu_b=0.
- Not defined: no rsp_err port; illegal opcodes are forwarded as described above.

Test Plan:
- ADD A=250, B=7 -> rsp_result=257, flags zero=0, carry=0, sign=0; rsp_valid one edge after accept.
- SUB A=5, B=5 -> rsp_result=0, zero=1, sign=0.
- SHL A=0x4001, count=3 -> 3 EXEC cycles, rsp_result=0x0008, carry=1 (sticky from pass 2), zero=0, sign=0; alu_a sequence 0x4001, 0x8002, 0x0004.
- Backpressure: OR A=8, B=2 with rsp_ready held 0 for 5 cycles -> rsp_result=10 stable, rsp_valid=1, req_ready=0 throughout; rsp_ready=1 -> IDLE, req_ready=1 next cycle.
- Reset mid-op: SHL A=1, count=15, rst_n pulsed low after 4 passes -> all outputs at reset values immediately; no rsp_valid; next ADD 1+1 returns 2.
- With ALU_SEQ_ERR_EN: op=12, A=3, B=4 -> rsp_err=1, rsp_result=0, zero=1. Without the macro: rsp_result=0, zero=1.
